// File: rtl/maq_pkg.sv
// Shared types and helpers for the clock's BCD digit machines.
package maq_pkg;

    typedef logic [3:0] bcd_t;

    function automatic bit bcd_valid(bcd_t d);
        return d <= 4'd9;
    endfunction

    function automatic int bcd2int(int msd, int lsd);
        return 10 * msd + lsd;
    endfunction

endpackage

// File: rtl/maq_bcd.sv
// Two-digit BCD modulo counter with up/down count, range-checked preset and
// single-cycle carry/borrow/load-error pulses; chained stage to stage via carry.
module maq_bcd
    import maq_pkg::*;
#(
    parameter int MSD_W   = 2,
    parameter int MAX_VAL = 23,
    parameter int MIN_VAL = 0
) (
    input  logic             maqbcd_clock,
    input  logic             maqbcd_reset,
    input  logic             maqbcd_enable,
    input  logic             maqbcd_incremento,
    input  logic             maqbcd_decremento,
    input  logic             maqbcd_load,
    input  bcd_t             maqbcd_load_lsd,
    input  logic [MSD_W-1:0] maqbcd_load_msd,
    output bcd_t             maqbcd_Lsd,
    output logic [MSD_W-1:0] maqbcd_Msd,
    output logic             maqbcd_carry,
    output logic             maqbcd_borrow,
    output logic             maqbcd_load_err
);

    localparam logic [MSD_W-1:0] MAX_MSD = MSD_W'(MAX_VAL / 10);
    localparam bcd_t             MAX_LSD = bcd_t'(MAX_VAL % 10);
    localparam logic [MSD_W-1:0] MIN_MSD = MSD_W'(MIN_VAL / 10);
    localparam bcd_t             MIN_LSD = bcd_t'(MIN_VAL % 10);
    localparam logic [MSD_W-1:0] MSD_ONE = MSD_W'(1);

    if (MAX_VAL > 99) begin : g_err_max_range
        $error("maq_bcd: MAX_VAL must not exceed 99");
    end
    if (MIN_VAL >= MAX_VAL) begin : g_err_min_range
        $error("maq_bcd: MIN_VAL must be below MAX_VAL");
    end
    if ((MAX_VAL / 10) > (2 ** MSD_W) - 1) begin : g_err_msd_width
        $error("maq_bcd: tens digit of MAX_VAL does not fit MSD_W");
    end

    typedef struct packed {
        logic [MSD_W-1:0] msd;
        bcd_t             lsd;
        logic             carry;
        logic             borrow;
        logic             load_err;
    } cnt_state_t;

    cnt_state_t cur;
    cnt_state_t nxt;

    logic step_up;
    logic step_down;
    logic at_max;
    logic at_min;
    logic load_ge_min;
    logic load_le_max;
    logic load_ok;

    // Range checks compare digit pairs against constants; the count is never converted to binary.
    assign at_max      = (cur.msd == MAX_MSD) && (cur.lsd == MAX_LSD);
    assign at_min      = (cur.msd == MIN_MSD) && (cur.lsd == MIN_LSD);
    assign load_ge_min = (maqbcd_load_msd > MIN_MSD) ||
                         ((maqbcd_load_msd == MIN_MSD) && (maqbcd_load_lsd >= MIN_LSD));
    assign load_le_max = (maqbcd_load_msd < MAX_MSD) ||
                         ((maqbcd_load_msd == MAX_MSD) && (maqbcd_load_lsd <= MAX_LSD));
    assign load_ok     = bcd_valid(maqbcd_load_lsd) && load_ge_min && load_le_max;

    assign step_up   = maqbcd_enable & maqbcd_incremento & ~maqbcd_decremento;
    assign step_down = maqbcd_enable & maqbcd_decremento & ~maqbcd_incremento;

    always_comb begin
        // NOTE: every field gets a default before any branch so no latch can be inferred.
        nxt          = cur;
        nxt.carry    = 1'b0;
        nxt.borrow   = 1'b0;
        nxt.load_err = 1'b0;
        if (maqbcd_load) begin
            if (load_ok) begin
                nxt.msd = maqbcd_load_msd;
                nxt.lsd = maqbcd_load_lsd;
            end else begin
                nxt.load_err = 1'b1;
            end
        end else if (step_up) begin
            if (at_max) begin
                nxt.msd   = MIN_MSD;
                nxt.lsd   = MIN_LSD;
                nxt.carry = 1'b1;
            end else if (cur.lsd == 4'd9) begin
                nxt.lsd = 4'd0;
                nxt.msd = cur.msd + MSD_ONE;
            end else begin
                nxt.lsd = cur.lsd + 4'd1;
            end
        end else if (step_down) begin
            if (at_min) begin
                nxt.msd    = MAX_MSD;
                nxt.lsd    = MAX_LSD;
                nxt.borrow = 1'b1;
            end else if (cur.lsd == 4'd0) begin
                nxt.lsd = 4'd9;
                nxt.msd = cur.msd - MSD_ONE;
            end else begin
                nxt.lsd = cur.lsd - 4'd1;
            end
        end
    end

    always_ff @(posedge maqbcd_clock or negedge maqbcd_reset) begin
        if (!maqbcd_reset) begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            cur.msd      <= MIN_MSD;
            cur.lsd      <= MIN_LSD;
            cur.carry    <= 1'b0;
            cur.borrow   <= 1'b0;
            cur.load_err <= 1'b0;
        end else begin
            cur <= nxt;
        end
    end

    assign maqbcd_Msd      = cur.msd;
    assign maqbcd_Lsd      = cur.lsd;
    assign maqbcd_carry    = cur.carry;
    assign maqbcd_borrow   = cur.borrow;
    assign maqbcd_load_err = cur.load_err;

endmodule

// File: tb/tb_maq_bcd.sv
// Self-checking bench: hours-24, minutes and hours-12 counters driven in parallel
// against an integer reference model, directed steps followed by random traffic.
module tb_maq_bcd;
    import maq_pkg::*;

    localparam int MAXV[3] = '{23, 59, 12};
    localparam int MINV[3] = '{0, 0, 1};
    localparam int WIDV[3] = '{2, 3, 2};

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       inc;
    logic       dec;
    logic       ld;
    logic [3:0] ld_lsd;
    logic [2:0] ld_msd;

    logic [3:0] a_lsd, b_lsd, c_lsd;
    logic [1:0] a_msd, c_msd;
    logic [2:0] b_msd;
    logic       a_c, a_b, a_e, b_c, b_b, b_e, c_c, c_b, c_e;

    int mval[3];
    bit mc[3], mb[3], me[3];
    int n_checks = 0;
    int n_errors = 0;

    maq_bcd #(.MSD_W(2), .MAX_VAL(23), .MIN_VAL(0)) u_hr24 (
        .maqbcd_clock(clk), .maqbcd_reset(rst_n), .maqbcd_enable(en),
        .maqbcd_incremento(inc), .maqbcd_decremento(dec), .maqbcd_load(ld),
        .maqbcd_load_lsd(ld_lsd), .maqbcd_load_msd(ld_msd[1:0]),
        .maqbcd_Lsd(a_lsd), .maqbcd_Msd(a_msd), .maqbcd_carry(a_c),
        .maqbcd_borrow(a_b), .maqbcd_load_err(a_e));

    maq_bcd #(.MSD_W(3), .MAX_VAL(59), .MIN_VAL(0)) u_min (
        .maqbcd_clock(clk), .maqbcd_reset(rst_n), .maqbcd_enable(en),
        .maqbcd_incremento(inc), .maqbcd_decremento(dec), .maqbcd_load(ld),
        .maqbcd_load_lsd(ld_lsd), .maqbcd_load_msd(ld_msd),
        .maqbcd_Lsd(b_lsd), .maqbcd_Msd(b_msd), .maqbcd_carry(b_c),
        .maqbcd_borrow(b_b), .maqbcd_load_err(b_e));

    maq_bcd #(.MSD_W(2), .MAX_VAL(12), .MIN_VAL(1)) u_hr12 (
        .maqbcd_clock(clk), .maqbcd_reset(rst_n), .maqbcd_enable(en),
        .maqbcd_incremento(inc), .maqbcd_decremento(dec), .maqbcd_load(ld),
        .maqbcd_load_lsd(ld_lsd), .maqbcd_load_msd(ld_msd[1:0]),
        .maqbcd_Lsd(c_lsd), .maqbcd_Msd(c_msd), .maqbcd_carry(c_c),
        .maqbcd_borrow(c_b), .maqbcd_load_err(c_e));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int i, input string nm, input logic [7:0] msd,
                             input logic [7:0] lsd, input logic c, input logic b,
                             input logic e);
        check({nm, ".msd"}, msd, 8'(mval[i] / 10));
        check({nm, ".lsd"}, lsd, 8'(mval[i] % 10));
        check({nm, ".carry"}, 8'(c), 8'(mc[i]));
        check({nm, ".borrow"}, 8'(b), 8'(mb[i]));
        check({nm, ".load_err"}, 8'(e), 8'(me[i]));
    endtask

    task automatic verify();
        check_dut(0, "hr24", 8'(a_msd), 8'(a_lsd), a_c, a_b, a_e);
        check_dut(1, "min", 8'(b_msd), 8'(b_lsd), b_c, b_b, b_e);
        check_dut(2, "hr12", 8'(c_msd), 8'(c_lsd), c_c, c_b, c_e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mval[i] = MINV[i];
            mc[i] = 1'b0;
            mb[i] = 1'b0;
            me[i] = 1'b0;
        end
    endtask

    // Reference: count held as a plain integer, stepped by modular arithmetic.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int m;
            int v;
            m = int'(ld_msd) & ((1 << WIDV[i]) - 1);
            v = bcd2int(m, int'(ld_lsd));
            mc[i] = 1'b0;
            mb[i] = 1'b0;
            me[i] = 1'b0;
            if (ld) begin
                if (ld_lsd <= 4'd9 && v >= MINV[i] && v <= MAXV[i]) mval[i] = v;
                else me[i] = 1'b1;
            end else if (en && inc && !dec) begin
                if (mval[i] == MAXV[i]) begin
                    mval[i] = MINV[i];
                    mc[i] = 1'b1;
                end else mval[i] = mval[i] + 1;
            end else if (en && dec && !inc) begin
                if (mval[i] == MINV[i]) begin
                    mval[i] = MAXV[i];
                    mb[i] = 1'b1;
                end else mval[i] = mval[i] - 1;
            end
        end
    endtask

    task automatic drive(input logic e, input logic up, input logic dn, input logic l,
                         input logic [2:0] msd, input logic [3:0] lsd);
        en = e;
        inc = up;
        dec = dn;
        ld = l;
        ld_msd = msd;
        ld_lsd = lsd;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        verify();
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        verify();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        model_reset();
        #12;
        verify();
        @(negedge clk);
        rst_n = 1'b1;

        // Count up through a full hours-24 cycle and one hold cycle after the wrap.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        repeat (24) cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        cycle();

        // Borrow from minimum, then plain down step.
        pulse_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
        cycle();
        cycle();

        // 12-hour wrap points and out-of-range preset.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 4'd2);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        cycle();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0);
        cycle();

        // Preset range and digit validity.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 4'd5);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 4'hA);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 4'd7);
        cycle();

        // Priority and gating.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        cycle();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 4'd5);
        cycle();

        // Asynchronous reset between edges while sitting at 19.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 4'd9);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        pulse_reset();
        cycle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
